// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the iterative AES-128 round sequencer.
package aes_pkg;

  localparam int unsigned AES_DATA_LEN = 128;
  localparam int unsigned AES_NR       = 10;
  localparam int unsigned AES_RIDX_W   = 4;
  localparam int unsigned AES_TIMEOUT  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer driving an external round datapath.
// Optional WAIT watchdog enabled by defining AES_CTRL_TIMEOUT_EN.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned DATA_LEN = AES_DATA_LEN,
  parameter int unsigned NR       = AES_NR,
  parameter int unsigned RIDX_W   = AES_RIDX_W,
  parameter int unsigned TIMEOUT  = AES_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] data_in,
  output logic [RIDX_W-1:0]   key_idx,
  input  logic [DATA_LEN-1:0] key_in,
  output logic                rnd_valid,
  output logic [DATA_LEN-1:0] rnd_data,
  output logic [DATA_LEN-1:0] rnd_key,
  output logic                rnd_last,
  input  logic                rnd_ret_valid,
  input  logic [DATA_LEN-1:0] rnd_ret_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] data_out,
  output logic                busy,
  output logic                err
);

  localparam logic [RIDX_W-1:0] LAST_RND = RIDX_W'(NR);

  // Reject configurations where the round index cannot reach NR.
  if (((2 ** RIDX_W) <= NR) || (TIMEOUT == 0)) begin : g_cfg_check
    $error("aes_round_ctrl: RIDX_W too narrow for NR or TIMEOUT is zero");
  end

  aes_state_e          state_q, state_d;
  logic [RIDX_W-1:0]   round_q, round_d;
  logic [DATA_LEN-1:0] state_reg_q, state_reg_d;

  logic                in_ready_q, in_ready_d;
  logic                rnd_valid_q, rnd_valid_d;
  logic                rnd_last_q, rnd_last_d;
  logic [DATA_LEN-1:0] rnd_data_q, rnd_data_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0] data_out_q, data_out_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

`ifdef AES_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state logic; output registers are derived from the next state.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    state_reg_d = state_reg_q;
    err_d       = 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_reg_d = data_in ^ key_in;
          round_d     = RIDX_W'(1);
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef AES_CTRL_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (rnd_ret_valid) begin
          state_reg_d = rnd_ret_data;
          if (round_q == LAST_RND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + RIDX_W'(1);
            state_d = ISSUE;
          end
        end
`ifdef AES_CTRL_TIMEOUT_EN
        // A return in the expiry cycle takes priority over the abort.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d       = 1'b1;
          state_d     = IDLE;
          state_reg_d = '0;
          round_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          round_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rnd_valid_d = (state_d == ISSUE);
    rnd_last_d  = (state_d == ISSUE) && (round_d == LAST_RND);
    rnd_data_d  = (state_d == ISSUE) ? state_reg_d : '0;
    out_valid_d = (state_d == DONE);
    data_out_d  = (state_d == DONE) ? state_reg_d : '0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      round_q     <= '0;
      state_reg_q <= '0;
      in_ready_q  <= 1'b1;
      rnd_valid_q <= 1'b0;
      rnd_last_q  <= 1'b0;
      rnd_data_q  <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      state_reg_q <= state_reg_d;
      in_ready_q  <= in_ready_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_last_q  <= rnd_last_d;
      rnd_data_q  <= rnd_data_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

`ifdef AES_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // round_q is zero in IDLE and equals the active round otherwise.
  assign key_idx   = round_q;
  assign in_ready  = in_ready_q;
  assign rnd_valid = rnd_valid_q;
  assign rnd_last  = rnd_last_q;
  assign rnd_data  = rnd_data_q;
  assign rnd_key   = rnd_valid_q ? key_in : '0;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
